// File: rtl/mem_arbiter.sv
// Round-robin memory arbiter with a post-reset tape clear and a
// fixed 2-cycle read-response pipeline routed back to the requesting core.
module mem_arbiter #(
    parameter int unsigned NCORES      = 4,
    parameter int unsigned CLEAR_DEPTH = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCORES-1:0]      req,
    input  logic [NCORES-1:0]      we,
    input  logic [NCORES*16-1:0]   addr,
    input  logic [NCORES*16-1:0]   wdata,
    output logic [NCORES-1:0]      gnt,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [15:0]            mem_addr,
    output logic [15:0]            mem_wdata,
    input  logic [15:0]            mem_rdata,
    output logic [NCORES-1:0]      rsp_valid,
    output logic [15:0]            rsp_data,
    output logic                   busy
);

    localparam int unsigned DW       = 16;
    localparam int unsigned AW       = 16;
    localparam int unsigned PW       = $clog2(NCORES);
    localparam int unsigned CLR_LAST = (CLEAR_DEPTH == 0) ? 0 : CLEAR_DEPTH - 1;
    localparam logic        CLR_EN   = (CLEAR_DEPTH != 0);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [AW-1:0]       cnt_q, cnt_d;
    logic [PW-1:0]       rr_q, rr_d;
    logic                rd_v1_q, rd_v1_d;
    logic [PW-1:0]       rd_id1_q, rd_id1_d;
    logic [NCORES-1:0]   rsp_valid_q, rsp_valid_d;

    logic [AW-1:0]       addr_a  [NCORES];
    logic [DW-1:0]       wdata_a [NCORES];
    logic                win_any;
    logic [PW-1:0]       win_idx;
    logic [PW-1:0]       cand;
    logic [NCORES-1:0]   win_onehot;
    logic [PW-1:0]       rr_next;

    // Unpack the flat per-core address and data buses
    for (genvar k = 0; k < NCORES; k++) begin : g_unpack
        assign addr_a[k]  = addr[k*16 +: 16];
        assign wdata_a[k] = wdata[k*16 +: 16];
    end

    // First requesting core at or above rr_q, wrapping around
    always_comb begin
        win_any = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int unsigned i = 0; i < NCORES; i++) begin
            cand = PW'((32'(rr_q) + i) % NCORES);
            if (!win_any && req[cand]) begin
                win_any = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign win_onehot = NCORES'(1) << win_idx;
    assign rr_next    = (win_idx == PW'(NCORES - 1)) ? '0 : win_idx + PW'(1);

    // Next state, memory port drive and response-pipeline entry
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rr_d      = rr_q;
        rd_v1_d   = 1'b0;
        rd_id1_d  = rd_id1_q;
        gnt       = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        busy      = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                busy     = 1'b1;
                // Gate with rst_n so the bus is quiet while reset is held
                mem_en   = CLR_EN & rst_n;
                mem_we   = CLR_EN & rst_n;
                mem_addr = cnt_q;
                cnt_d    = cnt_q + AW'(1);
                if (cnt_q == AW'(CLR_LAST)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (win_any) begin
                    gnt       = win_onehot;
                    mem_en    = 1'b1;
                    mem_we    = we[win_idx];
                    mem_addr  = addr_a[win_idx];
                    mem_wdata = wdata_a[win_idx];
                    rr_d      = rr_next;
                    rd_v1_d   = ~we[win_idx];
                    rd_id1_d  = win_idx;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // Second response stage decodes the stored core id to a one-hot strobe
    always_comb begin
        rsp_valid_d = '0;
        if (rd_v1_q) begin
            rsp_valid_d = NCORES'(1) << rd_id1_q;
        end
    end

    // State, pointer and response pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CLEAR;
            cnt_q       <= '0;
            rr_q        <= '0;
            rd_v1_q     <= 1'b0;
            rd_id1_q    <= '0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_q        <= rr_d;
            rd_v1_q     <= rd_v1_d;
            rd_id1_q    <= rd_id1_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by random traffic,
// checked every cycle against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int NC    = 4;
    localparam int DEPTH = 4;
    localparam int NADDR = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req, we;
    logic [63:0] addr, wdata;
    logic [3:0]  gnt;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  rsp_valid;
    logic [15:0] rsp_data;
    logic        busy;

    always #5 clk = ~clk;

    mem_arbiter #(.NCORES(NC), .CLEAR_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    // Memory with a 2-cycle read latency
    logic [15:0] init_val [NADDR];
    logic [15:0] env_mem  [NADDR];
    logic        written  [NADDR];
    logic [15:0] rd_p1;
    logic        mem_init;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < NADDR; i++) written[i] <= 1'b0;
        end else if (mem_en && mem_we) begin
            env_mem[mem_addr[4:0]] <= mem_wdata;
            written[mem_addr[4:0]] <= 1'b1;
        end
        rd_p1     <= written[mem_addr[4:0]] ? env_mem[mem_addr[4:0]] : init_val[mem_addr[4:0]];
        mem_rdata <= rd_p1;
    end

    // Reference model state
    typedef struct {
        int          due;
        int          core;
        logic [15:0] data;
    } rsp_t;

    bit          in_clear;
    int          clr_cnt;
    int          ptr;
    int          cyc;
    logic [15:0] ref_mem [NADDR];
    rsp_t        pend [$];
    int          tests;
    int          fails;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        in_clear = 1'b1;
        clr_cnt  = 0;
        ptr      = 0;
        pend.delete();
    endtask

    task automatic check_reset_outputs();
        chk("rst_gnt",       32'(gnt),       32'h0);
        chk("rst_mem_en",    32'(mem_en),    32'h0);
        chk("rst_mem_we",    32'(mem_we),    32'h0);
        chk("rst_busy",      32'(busy),      32'h1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    endtask

    task automatic set_core(input int k, input logic w, input logic [15:0] a, input logic [15:0] d);
        req[k]           = 1'b1;
        we[k]            = w;
        addr[k*16 +: 16]  = a;
        wdata[k*16 +: 16] = d;
    endtask

    // Check one cycle at the falling edge, advance the model, then move past the rising edge
    task automatic tick(output int gk);
        logic [3:0]  e_gnt, e_rv;
        logic        e_en, e_we, e_busy;
        logic [15:0] e_addr, e_wd, e_rd;
        int          c;
        @(negedge clk);
        gk = -1;
        e_gnt = '0; e_rv = '0; e_en = 1'b0; e_we = 1'b0; e_busy = 1'b0;
        e_addr = '0; e_wd = '0; e_rd = '0;
        if (in_clear) begin
            e_busy = 1'b1;
            e_en   = (DEPTH > 0);
            e_we   = e_en;
            e_addr = 16'(clr_cnt);
        end else begin
            for (int i = 0; i < NC; i++) begin
                c = (ptr + i) % NC;
                if (gk < 0 && req[c]) gk = c;
            end
            if (gk >= 0) begin
                e_gnt  = 4'(1 << gk);
                e_en   = 1'b1;
                e_we   = we[gk];
                e_addr = addr[gk*16 +: 16];
                e_wd   = wdata[gk*16 +: 16];
            end
        end
        if (pend.size() > 0 && pend[0].due == cyc) begin
            e_rv = 4'(1 << pend[0].core);
            e_rd = pend[0].data;
            void'(pend.pop_front());
        end
        chk("gnt",       32'(gnt),    32'(e_gnt));
        chk("mem_en",    32'(mem_en), 32'(e_en));
        chk("mem_we",    32'(mem_we), 32'(e_we));
        if (e_en) begin
            chk("mem_addr",  32'(mem_addr),  32'(e_addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
        end
        chk("busy",      32'(busy),      32'(e_busy));
        chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
        if (e_rv != 4'h0) chk("rsp_data", 32'(rsp_data), 32'(e_rd));
        if (in_clear) begin
            if (clr_cnt < NADDR) ref_mem[clr_cnt] = 16'h0;
            clr_cnt++;
            if (clr_cnt >= DEPTH) in_clear = 1'b0;
        end else if (gk >= 0) begin
            if (e_we) ref_mem[e_addr[4:0]] = e_wd;
            else      pend.push_back('{cyc + 2, gk, ref_mem[e_addr[4:0]]});
            ptr = (gk + 1) % NC;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // Short asynchronous reset pulse between clock edges
    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gk;
        tests = 0; fails = 0; cyc = 0;
        rst_n = 1'b0; mem_init = 1'b1;
        req = '0; we = '0; addr = '0; wdata = '0;
        for (int i = 0; i < NADDR; i++) begin
            init_val[i] = 16'($urandom);
            ref_mem[i]  = init_val[i];
        end
        init_val[16] = 16'hBEEF;
        ref_mem[16]  = 16'hBEEF;
        model_reset();

        // Reset held, core 3 already requesting
        repeat (2) @(posedge clk);
        #1;
        set_core(3, 1'b0, 16'h0005, 16'h0);
        #1;
        check_reset_outputs();
        mem_init = 1'b0;
        rst_n    = 1'b1;

        // Four clear cycles, then core 3 wins the first RUN cycle
        repeat (5) begin
            tick(gk);
            if (gk >= 0) req[gk] = 1'b0;
        end

        // Single read of 0xBEEF by core 2
        set_core(2, 1'b0, 16'h0010, 16'h0);
        tick(gk);
        if (gk >= 0) req[gk] = 1'b0;
        repeat (2) tick(gk);

        // Write by core 1, then quiet cycles with no response
        set_core(1, 1'b1, 16'h0003, 16'h0005);
        tick(gk);
        if (gk >= 0) req[gk] = 1'b0;
        repeat (3) tick(gk);

        // Core 3 write moves the pointer back to 0
        set_core(3, 1'b1, 16'h0007, 16'h1234);
        tick(gk);
        if (gk >= 0) req[gk] = 1'b0;

        // All four cores request continuously
        for (int k = 0; k < NC; k++) set_core(k, 1'b0, 16'(8 + k), 16'h0);
        repeat (5) tick(gk);
        req = '0;
        repeat (3) tick(gk);

        // Same-address write then read in consecutive cycles
        set_core(0, 1'b1, 16'h0009, 16'hA5A5);
        set_core(1, 1'b0, 16'h0009, 16'h0);
        repeat (2) begin
            tick(gk);
            if (gk >= 0) req[gk] = 1'b0;
        end
        repeat (3) tick(gk);

        // Reset one cycle after a read grant drops its response
        set_core(0, 1'b0, 16'h000C, 16'h0);
        tick(gk);
        if (gk >= 0) req[gk] = 1'b0;
        pulse_reset();
        repeat (6) tick(gk);

        // Random traffic with one reset in the middle
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < NC; k++) begin
                if (!req[k] && $urandom_range(0, 2) == 0)
                    set_core(k, 1'($urandom_range(0, 1)), 16'($urandom_range(0, NADDR - 1)), 16'($urandom));
            end
            tick(gk);
            if (gk >= 0) req[gk] = 1'b0;
            if (n == 200) pulse_reset();
        end
        req = '0;
        repeat (4) tick(gk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
